key_expand_ctrl: RTL and testbench
==================================

# key_expand_ctrl

Sequential key-expansion controller for the AES-128 decryptor. Loads a 128-bit cipher key, iterates the single-round combinational key schedule stage (KeyScheduler) ten times with an internally generated Rcon sequence, and stores all 11 round keys in a register file. The decrypt datapath then reads round keys by index, typically in reverse order (round 10 first).

## Interface

Parameters:
- `NR`, 10, number of expansion rounds; fixed for AES-128. The register file holds NR+1 entries.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_load`  in  1  one-cycle strobe; samples `key_in` and starts expansion.
- `key_in`  in  128  cipher key, column-major; word w0 is in [127:96].
- `busy`  out  1  high while expansion is running.
- `key_ready`  out  1  high when all 11 round keys are valid.
- `rd_en`  in  1  round-key read request.
- `rd_round`  in  4  requested round index, 0..10.
- `rd_key`  out  128  round key returned for the last accepted read.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_key`.

## Operation

- States are IDLE, EXPAND and READY. Reset places the block in IDLE with every register-file slot cleared.
- Reset values of all outputs are 0: `busy`, `key_ready`, `rd_key`, `rd_valid`.
- **key_load in any state:**
  - Write `key_in` to slot 0.
  - Set the round counter `cnt` to 1 and `rcon` to 8'h01.
  - Go to EXPAND, with `busy`=1 and `key_ready`=0.
  - A load during EXPAND aborts the current expansion and restarts it.
- **EXPAND, each cycle:**
  - slot[cnt] ← KeyScheduler(slot[cnt-1], rcon).
  - `rcon` ← xtime(rcon), i.e. shift left by one, XOR with 8'h1B if bit 7 was set.
  - `cnt` increments.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- **EXPAND exit:** after the write of slot 10, go to READY with `busy`=0 and `key_ready`=1.
- **READY:** holds until `key_load` or `rst`. Round keys remain stable.
- **Read port:**
  - If `rd_en` is high, `key_ready` is 1 and `rd_round` ≤ 10, then on the next edge `rd_key` ← slot[rd_round] and `rd_valid`=1 for one cycle.
  - If `rd_en` is high while `key_ready`=0, or `rd_round` > 10: `rd_valid` stays 0 and `rd_key` holds its previous value.
  - Back-to-back reads are accepted every cycle.
- **Simultaneous `key_load` and `rd_en` in READY:** the load wins and the read is dropped (`rd_valid`=0), because `key_ready` falls at the same edge.
- **`rst` mid-expansion:** the block returns immediately to IDLE with outputs 0. The partially written slots are cleared.

## Timing

- `key_load` sampled at edge E0: slot 0 written at E0, `busy`=1 after E0.
- Slots 1..10 are written at edges E1..E10.
- `busy` falls and `key_ready` rises after E10. Load-to-ready latency is 10 cycles.
- Read latency is 1 cycle from the `rd_en` edge to `rd_valid`/`rd_key`.
- The KeyScheduler path (S-box plus XOR chain) is combinational between the slot register and the next slot register, so it must close in one cycle.

## Configuration

- `KEYEXP_DEC_ORDER_EN`
  - Defined: `rd_round` is interpreted in decryption order, so index i returns slot[10-i] (`rd_round`=0 yields the round-10 key). The range check is unchanged (0..10).
  - Undefined: `rd_round` addresses slots directly (index i returns slot[i]).

## Test plan

- **Known-answer expansion:** reset, then `key_load` with `key_in`=2b7e151628aed2a6abf7158809cf4f3c → `key_ready` rises exactly 10 cycles later. Reads must return:
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 0: the key itself
  - With `KEYEXP_DEC_ORDER_EN`, index 0 returns d014f9a8… .
- **Reset values and reset mid-expansion:** check all outputs are 0 after reset. Assert `rst` 4 cycles into expansion → `busy`=0, `key_ready`=0. A later read of round 1 gives `rd_valid`=0.
- **Reload during EXPAND:** load key A, then 5 cycles later load the all-zero key. `key_ready` must rise 10 cycles after the second load. Round 10 must equal b4ef5bcb3e92e21123e951cf6f8f188e.
- **Read guards:** `rd_en` while busy → no `rd_valid`. `rd_round`=11 in READY → no `rd_valid`, `rd_key` unchanged.
- **Streaming and collision:** 11 back-to-back reads of rounds 10..0 → 11 consecutive `rd_valid` pulses with correct keys. `key_load` together with `rd_en` → `rd_valid`=0 and expansion restarts.

Source files
------------

// File: rtl/key_expand_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl_if
// Handshake bundle between the AES-128 decrypt datapath (master) and the
// round-key expansion controller (slave).
//   key_load  : one-cycle strobe, samples key_in and starts expansion
//   key_in    : 128-bit cipher key, word w0 in [127:96]
//   busy      : expansion in progress
//   key_ready : all round keys valid
//   rd_en     : round-key read request
//   rd_round  : requested round index 0..10
//   rd_key    : round key of the last accepted read
//   rd_valid  : one-cycle pulse qualifying rd_key
// -----------------------------------------------------------------------------
interface key_expand_ctrl_if;
   logic         key_load;
   logic [127:0] key_in;
   logic         busy;
   logic         key_ready;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic         rd_valid;

   modport master (
      output key_load, key_in, rd_en, rd_round,
      input  busy, key_ready, rd_key, rd_valid
   );

   modport slave (
      input  key_load, key_in, rd_en, rd_round,
      output busy, key_ready, rd_key, rd_valid
   );
endinterface

// File: rtl/key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// key_expand_ctrl
// Sequential AES-128 key-expansion controller. A loaded cipher key is expanded
// one round per clock into an (NR+1)-entry round-key register file, which the
// decrypt datapath then reads by index with one cycle of latency.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : key_expand_ctrl_if.slave (load strobe/key, status, read port)
//
// Build option:
//   KEYEXP_DEC_ORDER_EN : when defined, rd_round i returns slot[NR-i]
//                         (decryption order); otherwise slot[i].
// -----------------------------------------------------------------------------
module key_expand_ctrl #(
   parameter int NR = 10
) (
   input  logic              clk,
   input  logic              rst,
   key_expand_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;

   localparam logic [3:0] LAST = 4'(NR);

   // AES forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] top;
      top  = 11'h7FF - {x, 3'b000};
      sbox = SBOX_TABLE[top -: 8];
   endfunction

   // GF(2^8) doubling used to step the round constant.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // One AES-128 key-schedule round: previous round key -> next round key.
   function automatic logic [127:0] key_sched(input logic [127:0] prev,
                                              input logic [7:0]   rcon);
      logic [31:0] w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
      w0   = prev[127:96];
      w1   = prev[95:64];
      w2   = prev[63:32];
      w3   = prev[31:0];
      rot  = {w3[23:0], w3[31:24]};
      sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      temp = sub ^ {rcon, 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      key_sched = {n0, n1, n2, n3};
   endfunction

   logic [127:0] r_slot [0:NR];
   logic [1:0]   r_state;
   logic [3:0]   r_cnt;
   logic [7:0]   r_rcon;
   logic         r_busy;
   logic         r_key_ready;
   logic [127:0] r_rd_key;
   logic         r_rd_valid;

   logic [3:0]   w_prev_idx;
   logic [127:0] w_next_key;
   logic [3:0]   w_rd_slot;
   logic         w_rd_accept;

   // Next-round key from the previous slot, and read-port decode.
   always_comb begin
      w_prev_idx  = 4'd0;
      w_next_key  = 128'd0;
      w_rd_slot   = 4'd0;
      w_rd_accept = 1'b0;

      if (r_cnt != 4'd0) begin
         w_prev_idx = r_cnt - 4'd1;
      end else begin
         w_prev_idx = 4'd0;
      end
      w_next_key = key_sched(r_slot[w_prev_idx], r_rcon);

`ifdef KEYEXP_DEC_ORDER_EN
      w_rd_slot = LAST - bus.rd_round;
`else
      w_rd_slot = bus.rd_round;
`endif

      // A coincident load drops the read since key_ready falls at that edge.
      if (bus.rd_en && r_key_ready && (bus.rd_round <= LAST) && !bus.key_load) begin
         w_rd_accept = 1'b1;
      end else begin
         w_rd_accept = 1'b0;
      end
   end

   // Control FSM, round counter, Rcon sequencer and round-key register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_rcon      <= 8'h00;
         r_busy      <= 1'b0;
         r_key_ready <= 1'b0;
         for (int i = 0; i <= NR; i++) begin
            r_slot[i] <= 128'd0;
         end
      end else if (bus.key_load) begin
         // Load from any state; restarts an expansion already in flight.
         r_slot[0]   <= bus.key_in;
         r_cnt       <= 4'd1;
         r_rcon      <= 8'h01;
         r_state     <= ST_EXPAND;
         r_busy      <= 1'b1;
         r_key_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_EXPAND: begin
               r_slot[r_cnt] <= w_next_key;
               r_rcon        <= xtime(r_rcon);
               if (r_cnt == LAST) begin
                  r_state     <= ST_READY;
                  r_busy      <= 1'b0;
                  r_key_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_READY: begin
               r_state <= ST_READY;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_key_ready <= 1'b0;
            end
         endcase
      end
   end

   // Registered read port: one-cycle latency, rd_key held on rejected reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_key   <= 128'd0;
         r_rd_valid <= 1'b0;
      end else if (w_rd_accept) begin
         r_rd_key   <= r_slot[w_rd_slot];
         r_rd_valid <= 1'b1;
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

   assign bus.busy      = r_busy;
   assign bus.key_ready = r_key_ready;
   assign bus.rd_key    = r_rd_key;
   assign bus.rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_expand_ctrl
// Randomised scoreboard bench for key_expand_ctrl. Expected round keys come
// from a FIPS-197 word-array key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map. Reads push expected keys into a queue; a
// monitor pops and compares on every rd_valid pulse.
// -----------------------------------------------------------------------------
module tb_key_expand_ctrl;

   localparam logic [127:0] KAT_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KAT_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KAT_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic clk = 1'b0;
   logic rst = 1'b1;
   key_expand_ctrl_if bus();

   key_expand_ctrl #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;
   int n_pulse = 0;
   int streak = 0;
   int max_streak = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   sb_ref [0:255];
   logic [127:0] ref_rk [0:10];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] xb = x[7:0];
         for (int y = 1; y < 256; y++) begin
            if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
         end
         sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Textbook key expansion over the 44-word array.
   task automatic compute_ref(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [7:0]  rc [1:10];
      logic [7:0]  r = 8'h01;
      logic [31:0] t;
      for (int j = 1; j <= 10; j++) begin
         rc[j] = r;
         r = gmul(r, 8'h02);
      end
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
            t = t ^ {rc[i/4], 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k <= 10; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endtask

   // Index on rd_round that addresses a given slot (the mapping is its own inverse).
   function automatic logic [3:0] idx_of(input int s);
`ifdef KEYEXP_DEC_ORDER_EN
      return 4'(10 - s);
`else
      return 4'(s);
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] k);
      bus.key_load = 1'b1;
      bus.key_in   = k;
      cyc();
      bus.key_load = 1'b0;
   endtask

   // Count edges from the load edge until key_ready, bounded.
   task automatic wait_ready(input string name);
      int k = 0;
      while (!bus.key_ready && k < 30) begin
         cyc();
         k++;
      end
      check(name, 128'(k), 128'd10);
   endtask

   // Monitor: every rd_valid pulse must match the oldest expected key.
   always @(negedge clk) begin
      if (!rst && bus.rd_valid) begin
         n_pulse++;
         streak++;
         if (streak > max_streak) max_streak = streak;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rd_valid: got key %h with no read outstanding", bus.rd_key);
         end else begin
            check("rd_key", bus.rd_key, exp_q.pop_front());
         end
      end else begin
         streak = 0;
      end
   end

   initial begin
      logic [127:0] held;
      logic [127:0] rk;
      int base;
      bus.key_load = 1'b0;
      bus.key_in   = 128'd0;
      bus.rd_en    = 1'b0;
      bus.rd_round = 4'd0;
      build_sbox();
      repeat (3) cyc();
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_key_ready", 128'(bus.key_ready), 128'd0);
      check("rst_rd_key", bus.rd_key, 128'd0);
      check("rst_rd_valid", 128'(bus.rd_valid), 128'd0);
      rst = 1'b0;
      cyc();

      // Known answer, with reads attempted throughout the expansion.
      compute_ref(KAT_KEY);
      load(KAT_KEY);
      check("busy_after_load", 128'(bus.busy), 128'd1);
      bus.rd_en = 1'b1;
      bus.rd_round = idx_of(1);
      wait_ready("kat_latency");
      bus.rd_en = 1'b0;
      check("busy_done", 128'(bus.busy), 128'd0);
      check("no_valid_while_busy", 128'(bus.rd_valid), 128'd0);
      bus.rd_en = 1'b1;
      bus.rd_round = idx_of(1);  exp_q.push_back(KAT_R1);  cyc();
      bus.rd_round = idx_of(10); exp_q.push_back(KAT_R10); cyc();
      bus.rd_round = idx_of(0);  exp_q.push_back(KAT_KEY); cyc();
      bus.rd_round = 4'd0;       exp_q.push_back(ref_rk[idx_of(0)]); cyc();
      bus.rd_en = 1'b0;
      cyc();

      // Out-of-range index: no pulse, rd_key held.
      held = bus.rd_key;
      bus.rd_en = 1'b1;
      bus.rd_round = 4'd11;
      cyc();
      bus.rd_en = 1'b0;
      check("oor_rd_valid", 128'(bus.rd_valid), 128'd0);
      check("oor_rd_key_held", bus.rd_key, held);

      // Streaming rounds 10..0 back to back.
      cyc();
      base = n_pulse;
      max_streak = 0;
      bus.rd_en = 1'b1;
      for (int s = 10; s >= 0; s--) begin
         bus.rd_round = idx_of(s);
         exp_q.push_back(ref_rk[s]);
         cyc();
      end
      bus.rd_en = 1'b0;
      cyc();
      check("stream_pulses", 128'(n_pulse - base), 128'd11);
      check("stream_consecutive", 128'(max_streak), 128'd11);

      // Load colliding with a read: read dropped, expansion restarts.
      rk = {$urandom, $urandom, $urandom, $urandom};
      compute_ref(rk);
      bus.rd_en = 1'b1;
      bus.rd_round = 4'd3;
      load(rk);
      bus.rd_en = 1'b0;
      check("collide_rd_valid", 128'(bus.rd_valid), 128'd0);
      check("collide_busy", 128'(bus.busy), 128'd1);
      check("collide_key_ready", 128'(bus.key_ready), 128'd0);
      wait_ready("collide_latency");
      bus.rd_en = 1'b1;
      bus.rd_round = 4'd3; exp_q.push_back(ref_rk[idx_of(3)]); cyc();
      bus.rd_en = 1'b0;
      cyc();

      // Reload during expansion with the all-zero key.
      load({$urandom, $urandom, $urandom, $urandom});
      repeat (4) cyc();
      compute_ref(128'd0);
      load(128'd0);
      wait_ready("reload_latency");
      bus.rd_en = 1'b1;
      bus.rd_round = idx_of(10); exp_q.push_back(ZERO_R10); cyc();
      bus.rd_round = idx_of(5);  exp_q.push_back(ref_rk[5]); cyc();
      bus.rd_en = 1'b0;
      cyc();

      // Reset four cycles into an expansion.
      load(KAT_KEY);
      repeat (4) cyc();
      rst = 1'b1;
      #1;
      check("midrst_busy", 128'(bus.busy), 128'd0);
      check("midrst_key_ready", 128'(bus.key_ready), 128'd0);
      check("midrst_rd_key", bus.rd_key, 128'd0);
      cyc();
      rst = 1'b0;
      cyc();
      bus.rd_en = 1'b1;
      bus.rd_round = idx_of(1);
      cyc();
      bus.rd_en = 1'b0;
      check("midrst_read_valid", 128'(bus.rd_valid), 128'd0);
      check("midrst_still_idle", 128'(bus.key_ready), 128'd0);

      // Random keys with random in-range and out-of-range reads.
      for (int n = 0; n < 4; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         compute_ref(rk);
         load(rk);
         wait_ready("rand_latency");
         for (int r = 0; r < 16; r++) begin
            int idx = $urandom_range(0, 15);
            bus.rd_en = $urandom_range(0, 3) != 0;
            bus.rd_round = 4'(idx);
            if (bus.rd_en && idx <= 10) begin
`ifdef KEYEXP_DEC_ORDER_EN
               exp_q.push_back(ref_rk[10 - idx]);
`else
               exp_q.push_back(ref_rk[idx]);
`endif
            end
            cyc();
         end
         bus.rd_en = 1'b0;
         cyc();
      end

      repeat (2) cyc();
      check("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
